// File: rtl/act_load_pkg.sv
// Shared types and constants for the activation tile loader.
package act_load_pkg;

  // Default array dimension; also the tile geometry seen by Activation_Memory
  localparam int unsigned SIZE_DEF  = 8;

  // Post-ReLU activation word width, shared with Activation_Memory
  localparam int unsigned ACT_WIDTH = 7;

  // Loader FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Words per tile for a SIZE x SIZE array
  function automatic int unsigned mem_words(input int unsigned size);
    return size * size;
  endfunction

  // Length of the skewed systolic feed window
  function automatic int unsigned cal_cycles(input int unsigned size);
    return (2 * size) - 1;
  endfunction

  localparam int unsigned MEM_SIZE_DEF   = mem_words(SIZE_DEF);
  localparam int unsigned CAL_CYCLES_DEF = cal_cycles(SIZE_DEF);

endpackage

// File: rtl/act_relu7.sv
// Combinational ReLU: signed IN_WIDTH activation to unsigned 7-bit word.
module act_relu7
  import act_load_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  act,
  output logic [ACT_WIDTH-1:0] relu
);

  // Negative inputs clamp to zero; non-negative inputs keep their low bits
  always_comb begin
    relu = act[ACT_WIDTH-1:0];
    if (act[IN_WIDTH-1]) begin
      relu = '0;
    end
  end

endmodule

// File: rtl/activation_load_ctrl.sv
// Loads one SIZE*SIZE activation tile into Activation_Memory, then opens
// the Cal window that drives the skewed systolic feed.
module activation_load_ctrl
  import act_load_pkg::*;
#(
  parameter  int unsigned SIZE       = SIZE_DEF,
  parameter  int unsigned IN_WIDTH   = 8,
  localparam int unsigned MEM_SIZE   = mem_words(SIZE),
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE),
  localparam int unsigned CAL_CYCLES = cal_cycles(SIZE),
  localparam int unsigned CNT_WIDTH  = $clog2(CAL_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   act_in,
  input  logic                  act_in_valid,
  output logic                  act_in_ready,
  output logic [ACT_WIDTH-1:0]  Activation,
  output logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in,
  output logic                  load_mem_done,
  output logic                  Cal,
  output logic                  busy,
  output logic                  tile_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_CAL  = CNT_WIDTH'(CAL_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0]  cal_cnt;
  logic [ACT_WIDTH-1:0]  relu_val;
  logic                  accept;

  act_relu7 #(
    .IN_WIDTH (IN_WIDTH)
  ) u_relu (
    .act  (act_in),
    .relu (relu_val)
  );

  // Ready and busy follow the state register directly
  always_comb begin
    act_in_ready = (state == LOAD);
    busy         = (state != IDLE);
    accept       = act_in_ready && act_in_valid;
  end

  // Tile sequencer: beat counter, write port, Cal window and done pulse.
  // Cal is raised one cycle after entering CAL so the final write lands
  // before the downstream index starts sweeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      beat_cnt                  <= '0;
      cal_cnt                   <= '0;
      Activation                <= '0;
      Activation_Mem_Address_in <= '0;
      load_mem_done             <= 1'b1;
      Cal                       <= 1'b0;
      tile_done                 <= 1'b0;
    end else begin
      load_mem_done <= 1'b1;
      tile_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            beat_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            Activation                <= relu_val;
            Activation_Mem_Address_in <= beat_cnt;
            load_mem_done             <= 1'b0;
            beat_cnt                  <= beat_cnt + ADDR_WIDTH'(1);
            if (beat_cnt == LAST_BEAT) begin
              state   <= CAL;
              cal_cnt <= '0;
            end
          end
        end
        CAL: begin
          if (!Cal) begin
            Cal     <= 1'b1;
            cal_cnt <= '0;
          end else if (cal_cnt == LAST_CAL) begin
            Cal       <= 1'b0;
            tile_done <= 1'b1;
            state     <= DONE;
          end else begin
            cal_cnt <= cal_cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activation_load_ctrl.sv
// Directed bench for activation_load_ctrl (SIZE=8, IN_WIDTH=8).
module tb_activation_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] act_in;
  logic       act_in_valid;
  logic       act_in_ready;
  logic [6:0] Activation;
  logic [5:0] Activation_Mem_Address_in;
  logic       load_mem_done;
  logic       Cal;
  logic       busy;
  logic       tile_done;

  activation_load_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .act_in                    (act_in),
    .act_in_valid              (act_in_valid),
    .act_in_ready              (act_in_ready),
    .Activation                (Activation),
    .Activation_Mem_Address_in (Activation_Mem_Address_in),
    .load_mem_done             (load_mem_done),
    .Cal                       (Cal),
    .busy                      (busy),
    .tile_done                 (tile_done)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;

  // Memory model and event monitor, sampled at the active edge
  logic       clr;
  logic [6:0] mem     [64];
  int         hits    [64];
  logic [6:0] exp_mem [64];
  int cyc = 0;
  int wr_n, cal_n, td_n;
  int first_wr, last_wr, first_cal, last_cal, td_cyc;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (clr) begin
      wr_n = 0; cal_n = 0; td_n = 0;
      first_wr = 0; last_wr = 0; first_cal = 0; last_cal = 0; td_cyc = 0;
      for (int k = 0; k < 64; k++) begin
        hits[k] = 0;
        mem[k]  = 7'h7f;
      end
    end else begin
      if (!load_mem_done) begin
        if (wr_n == 0) first_wr = cyc;
        last_wr = cyc;
        wr_n = wr_n + 1;
        mem[Activation_Mem_Address_in]  = Activation;
        hits[Activation_Mem_Address_in] = hits[Activation_Mem_Address_in] + 1;
      end
      if (Cal) begin
        if (cal_n == 0) first_cal = cyc;
        last_cal = cyc;
        cal_n = cal_n + 1;
      end
      if (tile_done) begin
        td_n   = td_n + 1;
        td_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    assert (got === exp) pass_n++;
    else begin
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [6:0] relu_ref(input logic [7:0] v);
    return v[7] ? 7'd0 : v[6:0];
  endfunction

  function automatic int data_bad();
    int n = 0;
    for (int k = 0; k < 64; k++) if (mem[k] !== exp_mem[k]) n++;
    return n;
  endfunction

  function automatic int hits_bad();
    int n = 0;
    for (int k = 0; k < 64; k++) if (hits[k] != 1) n++;
    return n;
  endfunction

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one beat; returns at the negedge where its write is visible
  task automatic beat(input int idx, input logic [7:0] v);
    exp_mem[idx] = relu_ref(v);
    act_in       = v;
    act_in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int mul, input int off);
    for (int i = lo; i <= hi; i++) beat(i, 8'(i * mul + off));
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (td_n > 0) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; act_in = '0; act_in_valid = 1'b0; clr = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ldone",  32'(load_mem_done), 32'd1);
    chk("rst_cal",    32'(Cal), 32'd0);
    chk("rst_act",    32'(Activation), 32'd0);
    chk("rst_addr",   32'(Activation_Mem_Address_in), 32'd0);
    chk("rst_tdone",  32'(tile_done), 32'd0);
    chk("rst_ready",  32'(act_in_ready), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    rst = 1'b0;
    clr = 1'b0;

    // Valid while IDLE is ignored
    clear_mon();
    act_in = 8'd33; act_in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(act_in_ready), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_wr",    32'(wr_n), 32'd0);
    act_in_valid = 1'b0;

    // Tile 1: 64 back-to-back beats, value k
    clear_mon();
    pulse_start();
    chk("t1_ready", 32'(act_in_ready), 32'd1);
    send_range(0, 63, 1, 0);
    act_in_valid = 1'b0;
    chk("t1_cal_gap", 32'(Cal), 32'd0);
    wait_done("t1_done_timeout");
    chk("t1_wr_n",     32'(wr_n), 32'd64);
    chk("t1_data",     32'(data_bad()), 32'd0);
    chk("t1_hits",     32'(hits_bad()), 32'd0);
    chk("t1_cal_n",    32'(cal_n), 32'd15);
    chk("t1_cal_rise", 32'(first_cal - last_wr), 32'd1);
    chk("t1_td_after", 32'(td_cyc - last_cal), 32'd1);
    chk("t1_td_n",     32'(td_n), 32'd1);
    chk("t1_latency",  32'(td_cyc - first_wr), 32'd79);
    @(negedge clk);
    chk("t1_idle",     32'(busy), 32'd0);

    // Tile 2: ReLU corner values, new tile from address 0
    clear_mon();
    pulse_start();
    beat(0, 8'hfb);
    chk("relu_addr0", 32'(Activation_Mem_Address_in), 32'd0);
    chk("relu_m5",    32'(Activation), 32'd0);
    beat(1, 8'h80);
    chk("relu_m128",  32'(Activation), 32'd0);
    beat(2, 8'd0);
    chk("relu_0",     32'(Activation), 32'd0);
    beat(3, 8'd100);
    chk("relu_100",   32'(Activation), 32'd100);
    beat(4, 8'd127);
    chk("relu_127",   32'(Activation), 32'd127);
    send_range(5, 63, 7, 3);
    act_in_valid = 1'b0;
    wait_done("t2_done_timeout");
    chk("t2_data", 32'(data_bad()), 32'd0);

    // Tile 3: backpressure after beat 10
    clear_mon();
    @(negedge clk);
    pulse_start();
    send_range(0, 10, 3, 1);
    act_in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("bp_ldone", 32'(load_mem_done), 32'd1);
      chk("bp_addr",  32'(Activation_Mem_Address_in), 32'd10);
    end
    beat(11, 8'd77);
    chk("bp_addr11", 32'(Activation_Mem_Address_in), 32'd11);
    chk("bp_data11", 32'(Activation), 32'd77);
    send_range(12, 63, 3, 1);
    act_in_valid = 1'b0;
    wait_done("t3_done_timeout");
    chk("t3_wr_n", 32'(wr_n), 32'd64);
    chk("t3_data", 32'(data_bad()), 32'd0);

    // Tile 4: start pulses during LOAD and CAL are ignored; valid held in CAL
    clear_mon();
    @(negedge clk);
    pulse_start();
    send_range(0, 19, 5, 2);
    start = 1'b1;
    beat(20, 8'd9);
    start = 1'b0;
    send_range(21, 63, 5, 2);
    act_in = 8'd55;
    repeat (4) @(negedge clk);
    chk("cal_ready", 32'(act_in_ready), 32'd0);
    chk("cal_high",  32'(Cal), 32'd1);
    pulse_start();
    act_in_valid = 1'b0;
    wait_done("t4_done_timeout");
    chk("t4_wr_n",  32'(wr_n), 32'd64);
    chk("t4_hits",  32'(hits_bad()), 32'd0);
    chk("t4_data",  32'(data_bad()), 32'd0);
    chk("t4_cal_n", 32'(cal_n), 32'd15);
    chk("t4_td_n",  32'(td_n), 32'd1);

    // Reset at beat 30 of LOAD
    @(negedge clk);
    pulse_start();
    send_range(0, 29, 1, 5);
    rst = 1'b1;
    beat(30, 8'd44);
    rst = 1'b0;
    act_in_valid = 1'b0;
    chk("rl_ldone", 32'(load_mem_done), 32'd1);
    chk("rl_cal",   32'(Cal), 32'd0);
    chk("rl_busy",  32'(busy), 32'd0);
    chk("rl_ready", 32'(act_in_ready), 32'd0);

    // Reset in Cal cycle 7
    clear_mon();
    pulse_start();
    send_range(0, 63, 1, 5);
    act_in_valid = 1'b0;
    for (int n = 0; n < 40 && cal_n < 7; n++) @(negedge clk);
    chk("rc_reach7", 32'(cal_n), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rc_ldone", 32'(load_mem_done), 32'd1);
    chk("rc_cal",   32'(Cal), 32'd0);
    chk("rc_busy",  32'(busy), 32'd0);
    chk("rc_ready", 32'(act_in_ready), 32'd0);
    chk("rc_td_n",  32'(td_n), 32'd0);

    // start coincident with rst: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rs_busy", 32'(busy), 32'd0);

    // Clean tile after resets
    clear_mon();
    pulse_start();
    send_range(0, 63, 11, 6);
    act_in_valid = 1'b0;
    wait_done("t5_done_timeout");
    chk("t5_wr_n",  32'(wr_n), 32'd64);
    chk("t5_hits",  32'(hits_bad()), 32'd0);
    chk("t5_data",  32'(data_bad()), 32'd0);
    chk("t5_cal_n", 32'(cal_n), 32'd15);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
